// File: rtl/dff_pkg.sv
// Shared constants and helpers for the Dff register family.
package dff_pkg;

    localparam int DFF_WIDTH = 8;
    localparam int DFF_DEPTH = 3;
    localparam logic DFF_RESET_BIT = 1'b0;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic register stage: holds a word until the next stage can take it.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_valid,
    input  logic             next_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ready
);

    assign ready = !valid || next_ready;

    // clear drops the valid bit only; the data register keeps its last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Chain of DEPTH elastic stages with valid/ready on both ends and an occupancy count.
// Optional synchronous flush port enabled by defining DFF_PIPE_FLUSH_EN.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_WIDTH,
    parameter int               DEPTH     = DFF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic [WIDTH-1:0]               in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int CW = count_width(DEPTH);

    // Handshake: a word moves across a boundary on a clock edge only when the
    // sender's valid and the receiver's ready are both high in that cycle;
    // valid never waits on ready, and the sender holds its word while stalled.

    // Index i is the input of stage i; index DEPTH is the pipe output.
    logic [WIDTH-1:0] stage_data  [DEPTH+1];
    logic             stage_valid [DEPTH+1];
    logic             stage_ready [DEPTH+1];
    logic             clear;
    logic             in_xfer;
    logic             out_xfer;

`ifdef DFF_PIPE_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign stage_data[0]      = in;
    assign stage_valid[0]     = in_valid;
    assign stage_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .prev_data  (stage_data[i]),
            .prev_valid (stage_valid[i]),
            .next_ready (stage_ready[i+1]),
            .data       (stage_data[i+1]),
            .valid      (stage_valid[i+1]),
            .ready      (stage_ready[i])
        );
    end

    assign in_ready  = stage_ready[0] && !clear;
    assign out       = stage_data[DEPTH];
    assign out_valid = stage_valid[DEPTH];

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and random checks of dff_pipe against a word-position reference model.
module tb_dff_pipe;
    import dff_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic [WIDTH-1:0]              in = '0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [WIDTH-1:0]              out;
    logic                          out_valid;
    logic                          out_ready = 1'b0;
    logic [count_width(DEPTH)-1:0] count;
`ifdef DFF_PIPE_FLUSH_EN
    logic                          flush = 1'b0;
`endif

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef DFF_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: words in order (head = oldest) with their stage position.
    int               pos_q[$];
    logic [WIDTH-1:0] dat_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each word moves one stage forward unless the word ahead still blocks it.
    task automatic model_advance(input logic in_x, input logic out_x, input logic [WIDTH-1:0] d);
        int               np[$];
        logic [WIDTH-1:0] nd[$];
        int               lim;
        int               p;
        lim = DEPTH;
        foreach (pos_q[k]) begin
            if (k == 0 && out_x) continue;
            p = (pos_q[k] + 1 < lim - 1) ? pos_q[k] + 1 : lim - 1;
            np.push_back(p);
            nd.push_back(dat_q[k]);
            lim = p;
        end
        if (in_x) begin
            np.push_back(0);
            nd.push_back(d);
        end
        pos_q = np;
        dat_q = nd;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy, output logic acc);
        logic exp_ov;
        logic exp_ir;
        @(negedge clk);
        in_valid  = v;
        in        = d;
        out_ready = ordy;
        #1;
        exp_ov = (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
        exp_ir = (pos_q.size() < DEPTH) || ordy;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) check("out", 32'(out), 32'(dat_q[0]));
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("count", 32'(count), 32'(pos_q.size()));
        check("count_bound", 32'(count <= DEPTH), 32'd1);
        acc = v && exp_ir;
        @(posedge clk);
        model_advance(acc, exp_ov && ordy, d);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 255), ordy, acc);
    endtask

    // Offer one word until it is accepted; the word stays stable while stalled.
    task automatic send(input logic [WIDTH-1:0] d, input logic ordy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            step(1'b1, d, ordy, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_stalled_then_release(input logic [WIDTH-1:0] d);
        logic acc;
        int   tries;
        step(1'b1, d, 1'b0, acc);
        tries = 0;
        while (!acc && tries < 64) begin
            step(1'b1, d, 1'b1, acc);
            tries++;
        end
        if (!acc) check("release_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic acc;

        // Reset held with in_valid high.
        reset    = 1'b0;
        in_valid = 1'b1;
        in       = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_out", 32'(out), 32'(RESET_VAL));
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single word latency.
        send(8'hA5, 1'b1);
        idle(5, 1'b1);

        // Streaming 0x01..0x10 back to back.
        for (int w = 1; w <= 16; w++) send(8'(w), 1'b1);
        idle(5, 1'b1);

        // Back-pressure: three fill, the fourth waits until out_ready rises.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0, acc);
        check("bp_held", 32'(acc), 32'd0);
        step(1'b1, 8'h44, 1'b0, acc);
        send_stalled_then_release(8'h44);
        idle(6, 1'b1);

        // Bubble collapse.
        send(8'h55, 1'b0);
        idle(2, 1'b0);
        send(8'h66, 1'b0);
        idle(3, 1'b0);
        check("bubble_count", 32'(count), 32'd2);

        // Asynchronous reset with two words in flight.
        @(negedge clk);
        in_valid = 1'b1;
        in       = 8'h77;
        reset    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        pos_q.delete();
        dat_q.delete();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        idle(5, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        end
        idle(6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
